// File: rtl/owire_pkg.sv
// Shared types and constants for the 1-Wire slave command receiver.
package owire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRES_WAIT,
      ST_PRESENCE,
      ST_CMD_IDLE,
      ST_CMD_SLOT,
      ST_DECODE,
      ST_SEND_ROM
   } state_t;

   localparam logic [7:0] CMD_READ_ROM   = 8'h33;
   localparam logic [7:0] CMD_SKIP_ROM   = 8'hCC;
   localparam logic [7:0] CMD_MATCH_ROM  = 8'h55;
   localparam logic [7:0] CMD_SEARCH_ROM = 8'hF0;

   // Default bus timing, in clock cycles (1 cycle = 1 us)
   localparam int DEF_RESET_MIN = 480;
   localparam int DEF_PRES_WAIT = 30;
   localparam int DEF_PRES_LEN  = 120;
   localparam int DEF_SAMPLE_PT = 15;
   localparam int DEF_CNT_W     = 10;

endpackage

// File: rtl/owire_bus_sync.sv
// Two-flop synchroniser for the raw 1-Wire line plus edge pulses.
// All flops reset to 1 so an idle (high) bus produces no spurious edge.
module owire_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic bus,
   output logic bus_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic bus_s_prev;

   // Synchroniser chain and one-cycle history for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta       <= 1'b1;
         bus_s      <= 1'b1;
         bus_s_prev <= 1'b1;
      end else begin
         meta       <= bus;
         bus_s      <= meta;
         bus_s_prev <= bus_s;
      end
   end

   assign fall = bus_s_prev & ~bus_s;
   assign rise = ~bus_s_prev & bus_s;

endmodule

// File: rtl/owire_slave_cmd_rx.sv
// 1-Wire slave front end: reset detect, presence pulse, ROM command
// receive (LSB first) and hand-off to the ROM sender on READ ROM.
module owire_slave_cmd_rx
   import owire_pkg::*;
#(
   parameter int RESET_MIN = DEF_RESET_MIN,
   parameter int PRES_WAIT = DEF_PRES_WAIT,
   parameter int PRES_LEN  = DEF_PRES_LEN,   // must be >= 2
   parameter int SAMPLE_PT = DEF_SAMPLE_PT,
   parameter int CNT_W     = DEF_CNT_W
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       bus,
   output logic       slave_pull_low,
   output logic       en_rom_sender,
   input  logic       done_sending_rom,
   output logic [7:0] cmd_byte,
   output logic       cmd_valid,
   output logic       presence_done,
   output logic       unsupported_cmd
);

   logic             bus_s;
   logic             rise;
   logic             fall;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] low_cnt;
   logic [7:0]       shift;
   logic [3:0]       bit_cnt;
   logic             sampled;
   logic             reset_det;
   logic             in_presence;

   owire_bus_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .bus_s (bus_s),
      .rise  (rise),
      .fall  (fall)
   );

   // Our own presence pulse must never be mistaken for a master reset
   assign in_presence = (state == ST_PRES_WAIT) || (state == ST_PRESENCE);
   assign reset_det   = rise && !in_presence && (low_cnt >= CNT_W'(RESET_MIN));

   // Length of the current low period, saturating at the reset threshold
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         low_cnt <= '0;
      else if (in_presence || bus_s)
         low_cnt <= '0;
      else if (low_cnt != CNT_W'(RESET_MIN))
         low_cnt <= low_cnt + 1'b1;
   end

   // Main FSM; reset detect overrides every state's own transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         shift           <= '0;
         bit_cnt         <= '0;
         sampled         <= 1'b0;
         slave_pull_low  <= 1'b0;
         en_rom_sender   <= 1'b0;
         cmd_byte        <= '0;
         cmd_valid       <= 1'b0;
         presence_done   <= 1'b0;
         unsupported_cmd <= 1'b0;
      end else begin
         cmd_valid       <= 1'b0;
         presence_done   <= 1'b0;
         unsupported_cmd <= 1'b0;
         if (reset_det) begin
            state          <= ST_PRES_WAIT;
            cnt            <= '0;
            shift          <= '0;
            bit_cnt        <= '0;
            sampled        <= 1'b0;
            slave_pull_low <= 1'b0;
            en_rom_sender  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_PRES_WAIT: begin
                  if (cnt == CNT_W'(PRES_WAIT - 1)) begin
                     state          <= ST_PRESENCE;
                     cnt            <= '0;
                     slave_pull_low <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_PRESENCE: begin
                  cnt <= cnt + 1'b1;
                  // Look one cycle ahead so the pulse lands on the last pull-low cycle
                  if (cnt == CNT_W'(PRES_LEN - 2))
                     presence_done <= 1'b1;
                  if (cnt == CNT_W'(PRES_LEN - 1)) begin
                     state          <= ST_CMD_IDLE;
                     cnt            <= '0;
                     slave_pull_low <= 1'b0;
                  end
               end
               ST_CMD_IDLE: begin
                  if (fall) begin
                     state   <= ST_CMD_SLOT;
                     cnt     <= CNT_W'(1);
                     sampled <= 1'b0;
                  end
               end
               ST_CMD_SLOT: begin
                  if (cnt != '1)
                     cnt <= cnt + 1'b1;
                  if (!sampled) begin
                     // An early release means the master wrote a 1
                     if (bus_s || cnt == CNT_W'(SAMPLE_PT)) begin
                        shift[bit_cnt[2:0]] <= bus_s;
                        bit_cnt             <= bit_cnt + 1'b1;
                        sampled             <= 1'b1;
                     end
                  end else if (bus_s) begin
                     if (bit_cnt == 4'd8) begin
                        state           <= ST_DECODE;
                        cmd_byte        <= shift;
                        cmd_valid       <= 1'b1;
                        unsupported_cmd <= (shift != CMD_READ_ROM);
                     end else begin
                        state <= ST_CMD_IDLE;
                     end
                  end
               end
               ST_DECODE: begin
                  shift   <= '0;
                  bit_cnt <= '0;
                  if (cmd_byte == CMD_READ_ROM) begin
                     state         <= ST_SEND_ROM;
                     en_rom_sender <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_SEND_ROM: begin
                  if (done_sending_rom) begin
                     state         <= ST_IDLE;
                     en_rom_sender <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_owire_slave_cmd_rx.sv
// Scoreboard bench for owire_slave_cmd_rx: a wired-AND bus model, master
// reset/slot stimulus, and expected presence/command events in a queue.
module tb_owire_slave_cmd_rx;
   import owire_pkg::*;

   localparam int PRES_LEN_T = 120;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       master_low = 1'b0;
   logic       done_sending_rom = 1'b0;
   logic       bus;
   logic       slave_pull_low;
   logic       en_rom_sender;
   logic [7:0] cmd_byte;
   logic       cmd_valid;
   logic       presence_done;
   logic       unsupported_cmd;

   assign bus = ~(master_low | slave_pull_low);

   always #5 clk = ~clk;

   owire_slave_cmd_rx dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .slave_pull_low   (slave_pull_low),
      .en_rom_sender    (en_rom_sender),
      .done_sending_rom (done_sending_rom),
      .cmd_byte         (cmd_byte),
      .cmd_valid        (cmd_valid),
      .presence_done    (presence_done),
      .unsupported_cmd  (unsupported_cmd)
   );

   typedef struct {
      bit         is_cmd;
      logic [7:0] val;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   pl_len = 0;
   bit   en_pend = 1'b0;
   logic en_exp = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on presence_done / cmd_valid
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         pl_len  = 0;
         en_pend = 1'b0;
      end else begin
         pl_len = slave_pull_low ? pl_len + 1 : 0;
         if (en_pend) begin
            chk("en_after_cmd", en_rom_sender, en_exp);
            en_pend = 1'b0;
         end
         if (presence_done) begin
            if (q.size() == 0) chk("unexpected_presence", 1, 0);
            else begin
               e = q.pop_front();
               chk("presence_kind", e.is_cmd, 0);
               chk("presence_len", pl_len, PRES_LEN_T);
            end
         end
         if (cmd_valid) begin
            if (q.size() == 0) chk("unexpected_cmd", 1, 0);
            else begin
               e = q.pop_front();
               chk("cmd_kind", e.is_cmd, 1);
               chk("cmd_byte", cmd_byte, e.val);
               chk("unsupported", unsupported_cmd, e.val != 8'h33);
               en_pend = 1'b1;
               en_exp  = (e.val == 8'h33);
            end
         end
      end
   end

   task automatic bus_low(input int n);
      @(posedge clk); #1 master_low = 1'b1;
      repeat (n) @(posedge clk);
      #1 master_low = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int lim);
      for (int k = 0; k < lim && q.size() != 0; k++) @(negedge clk);
      chk(tag, q.size(), 0);
   endtask

   task automatic reset_presence();
      q.push_back('{1'b0, 8'h00});
      bus_low(480);
      wait_drain("presence_seen", 400);
      repeat (20) @(posedge clk);
   endtask

   task automatic send_bit(input bit b);
      bus_low(b ? 6 : 60);
      repeat (10) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      q.push_back('{1'b1, b});
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic done_pulse();
      @(posedge clk); #1 done_sending_rom = 1'b1;
      @(posedge clk); #1 done_sending_rom = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pull"}, slave_pull_low, 0);
      chk({tag, "_en"}, en_rom_sender, 0);
      chk({tag, "_byte"}, cmd_byte, 8'h00);
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_pdone"}, presence_done, 0);
      chk({tag, "_unsup"}, unsupported_cmd, 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int hi;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // 479-cycle low from IDLE is not a reset
      bus_low(479);
      hi = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (slave_pull_low) hi++;
      end
      chk("no_presence_479", hi, 0);

      // 480-cycle low: pull-low starts 2 sync + 30 wait cycles after the
      // first high sample, i.e. on the 33rd rising edge after release
      q.push_back('{1'b0, 8'h00});
      bus_low(480);
      n = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (slave_pull_low) begin n = k; break; end
      end
      chk("pres_latency", n, 33);
      wait_drain("presence_480", 300);
      repeat (20) @(posedge clk);

      // READ ROM: enable held until done
      reset_presence();
      send_byte(CMD_READ_ROM);
      wait_drain("cmd_33", 50);
      repeat (3) @(negedge clk);
      chk("en_hold", en_rom_sender, 1);
      done_pulse();
      chk("en_after_done", en_rom_sender, 0);

      // SKIP ROM is unsupported here
      reset_presence();
      send_byte(CMD_SKIP_ROM);
      wait_drain("cmd_cc", 50);
      repeat (5) @(negedge clk);
      chk("en_idle_cc", en_rom_sender, 0);

      // Master reset during ROM send
      reset_presence();
      send_byte(CMD_READ_ROM);
      wait_drain("cmd_33_b", 50);
      q.push_back('{1'b0, 8'h00});
      bus_low(500);
      chk("en_during_low", en_rom_sender, 1);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (!en_rom_sender) begin n = k; break; end
      end
      chk("en_drop_latency", n, 3);
      wait_drain("re_presence", 400);
      repeat (20) @(posedge clk);

      // Async reset mid-slot after four bits of 0x33
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(posedge clk); #1 master_low = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_all_zero("midslot_rst");
      master_low = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      reset_presence();
      send_byte(CMD_READ_ROM);
      wait_drain("cmd_33_after_rst", 50);
      repeat (2) @(negedge clk);
      chk("en_after_rst", en_rom_sender, 1);
      done_pulse();
      chk("en_after_done2", en_rom_sender, 0);

      repeat (10) @(posedge clk);
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/owire_slave_cmd_rx.md
Name: owire_slave_cmd_rx

Overview:
- 1-Wire slave front end. Detects the master reset pulse and answers with a presence pulse.
- Then receives the 8-bit ROM command, LSB first, with a sample point inside each master-initiated slot.
- On READ ROM (0x33) it enables the downstream ROM sender, which shares the bus pull-down, and holds it enabled until that sender reports completion.
- Sits between the pad/bus and the ROM sender in the slave datapath.

Parameters:
- RESET_MIN, 480, minimum bus-low cycles recognised as a reset pulse (1 cycle = 1 us).
- PRES_WAIT, 30, cycles from bus release to start of presence pulse.
- PRES_LEN, 120, cycles the slave pulls low for presence.
- SAMPLE_PT, 15, cycles after a slot's falling edge at which the command bit is sampled.
- CNT_W, 10, width of timing counters; must hold RESET_MIN+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bus  in  1  raw 1-Wire line (asynchronous)
- slave_pull_low  out  1  1 = this block drives the line low; ORed externally with the ROM sender's pull-down
- en_rom_sender  out  1  level enable to the ROM sender
- done_sending_rom  in  1  ROM sender completion, sampled only while en_rom_sender=1
- cmd_byte  out  8  last received command, held until next command completes
- cmd_valid  out  1  one-cycle pulse when cmd_byte updates
- presence_done  out  1  one-cycle pulse at end of presence pulse
- unsupported_cmd  out  1  one-cycle pulse, concurrent with cmd_valid, when the command is not 0x33

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; cmd_byte=0x00; counters, shift register and bit count cleared; sync flops set to 1 (idle-high bus).
- bus passes a 2-flop synchroniser giving bus_s; fall = bus_s_prev & ~bus_s; rise = ~bus_s_prev & bus_s. All decisions use bus_s, so 2-cycle input latency.
- low_cnt counts every cycle bus_s=0, saturates at RESET_MIN, and clears on bus_s=1.
  - Frozen at 0 in states PRES_WAIT and PRESENCE.
- Global reset detect: in any state except PRES_WAIT/PRESENCE, a rise with low_cnt >= RESET_MIN forces PRES_WAIT next cycle.
  - This aborts the command receive; shift register and bit count are cleared.
  - en_rom_sender drops to 0 on that same edge (reset mid-ROM-send).
  - A low of exactly RESET_MIN-1 cycles is not a reset.
- States:
  - IDLE: wait for a reset detect.
  - PRES_WAIT: cnt counts 0..PRES_WAIT-1, then PRESENCE.
  - PRESENCE: slave_pull_low=1 for exactly PRES_LEN cycles. On the final cycle, presence_done=1 and the next state is CMD_IDLE with slave_pull_low=0.
  - CMD_IDLE: on fall, go to CMD_SLOT with cnt=1.
  - CMD_SLOT: cnt increments. When cnt==SAMPLE_PT, shift bus_s into bit[bit_cnt] (LSB first) and increment bit_cnt. After sampling, wait for bus_s=1.
    - If bit_cnt==8: go to DECODE.
    - Otherwise: go to CMD_IDLE.
    - If the line rises before SAMPLE_PT, the slot is a 1 recorded early: the sample is taken as 1 at the rise cycle.
  - DECODE (1 cycle): cmd_byte<=shift, cmd_valid=1.
    - If shift==0x33, go to SEND_ROM.
    - Otherwise unsupported_cmd=1 and go to IDLE (slave silent until next reset).
  - SEND_ROM: en_rom_sender=1, slave_pull_low=0. When done_sending_rom=1, en_rom_sender=0 next cycle and go to IDLE.
- slave_pull_low is 1 only in PRESENCE; the block never drives in any other state.
- Simultaneous done_sending_rom and reset-detect rise: the reset wins (PRES_WAIT); no extra cycle of en_rom_sender.
- bit_cnt is 4 bits and never wraps past 8.

Decomposition:
- Package owire_pkg holds:
  - the state enum (IDLE, PRES_WAIT, PRESENCE, CMD_IDLE, CMD_SLOT, DECODE, SEND_ROM);
  - command constants CMD_READ_ROM=8'h33, CMD_SKIP_ROM=8'hCC, CMD_MATCH_ROM=8'h55, CMD_SEARCH_ROM=8'hF0;
  - default timing constants.
- One sub-module, owire_bus_sync: 2-flop synchroniser plus rise/fall pulses, async reset to 1.

Test Plan:
- bus low 480 cycles then high -> after 2+30 cycles slave_pull_low=1 for 120 cycles; presence_done pulses once at the end.
- bus low 479 cycles then high -> no presence; slave_pull_low stays 0; state IDLE.
- Reset, presence, then 8 slots for 0x33 (1-bits: low 6 cycles; 0-bits: low 60 cycles; 10-cycle recovery) -> cmd_valid with cmd_byte=0x33; en_rom_sender=1 next cycle; done_sending_rom pulse -> en_rom_sender=0 next cycle.
- Same sequence sending 0xCC -> cmd_valid and unsupported_cmd pulse together; cmd_byte=0xCC; en_rom_sender stays 0.
- While in SEND_ROM, bus low 500 cycles then high -> en_rom_sender drops on the rise; a new presence pulse follows.
- rst asserted mid-slot after 4 bits -> outputs 0 immediately; after release and a fresh reset pulse, command 0x33 decodes correctly.
